// File: rtl/dff_pipe_pkg.sv
// Shared constants, types and helpers for the dff_pipe register pipeline.
package dff_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Classification of what happens at one clock edge, used for the occupancy count.
  typedef enum logic [1:0] {
    XFER_NONE = 2'b00,
    XFER_OUT  = 2'b01,
    XFER_IN   = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

  // Ceiling log2, never below 1 so the result is always a usable vector width.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Handshake bundle between a producer/consumer pair and the dff_pipe pipeline.
interface dff_pipe_if
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OCC_W = clog2(DEFAULT_DEPTH + 1)
);

  logic [WIDTH-1:0] D;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] Q;
  logic             out_valid;
  logic             out_ready;
  logic [OCC_W-1:0] occupancy;

  // Environment side: drives write data, flush and the consumer ready.
  modport master (
    output D, in_valid, flush, out_ready,
    input  in_ready, Q, out_valid, occupancy
  );

  // Pipeline side.
  modport slave (
    input  D, in_valid, flush, out_ready,
    output in_ready, Q, out_valid, occupancy
  );

endinterface

// File: rtl/dff_pipe_stage.sv
// One pipeline slot: a valid flag plus a data register that only changes when written.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  // Valid flag: clear wins, a write fills the slot, an outgoing item empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (clr) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
    end else if (drain) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Data register: holds its last value unless the slot is written or cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= RESET_VAL;
    end else if (clr) begin
      data_r <= RESET_VAL;
    end else if (load) begin
      data_r <= data_in;
    end else begin
      data_r <= data_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/dff_pipe.sv
// Elastic register pipeline of DEPTH slots with bubble collapse, flush and occupancy count.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic     clk,
  input  logic     reset,
  dff_pipe_if.slave bus
);

  localparam int OCC_W = clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_s;
  logic [DEPTH-1:0] move_s;
  logic [DEPTH-1:0] load_s;
  logic [WIDTH-1:0] data_s [DEPTH];
  logic             accept_s;
  logic             out_xfer_s;
  xfer_e            xfer_s;
  logic [OCC_W-1:0] occ_r;

  // Movement resolves from the output backwards: a slot moves when it is full and
  // the slot ahead is either empty or itself moving this cycle.
  always_comb begin
    move_s          = '0;
    move_s[DEPTH-1] = valid_s[DEPTH-1] & bus.out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      move_s[i] = valid_s[i] & (~valid_s[i+1] | move_s[i+1]);
    end
  end

  // Slot 0 is written by an accepted input, every later slot by its predecessor moving.
  always_comb begin
    load_s    = '0;
    load_s[0] = accept_s;
    for (int i = 1; i < DEPTH; i++) begin
      load_s[i] = move_s[i-1];
    end
  end

  // Input side is closed while flushing or while reset is held low.
  assign bus.in_ready = (~valid_s[0] | move_s[0]) & ~bus.flush & reset;
  assign accept_s     = bus.in_valid & bus.in_ready;
  assign out_xfer_s   = valid_s[DEPTH-1] & bus.out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] stage_in_s;

    if (g == 0) begin : g_head
      assign stage_in_s = bus.D;
    end else begin : g_body
      assign stage_in_s = data_s[g-1];
    end

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst_n   (reset),
      .clr     (bus.flush),
      .load    (load_s[g]),
      .drain   (move_s[g]),
      .data_in (stage_in_s),
      .valid   (valid_s[g]),
      .data    (data_s[g])
    );
  end

  // Classify this cycle's transfers for the occupancy update.
  always_comb begin
    xfer_s = xfer_e'({accept_s, out_xfer_s});
  end

  // Occupancy counter: +1 on accept, -1 on output, zero after flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_r <= '0;
    end else if (bus.flush) begin
      occ_r <= '0;
    end else begin
      case (xfer_s)
        XFER_IN:  occ_r <= occ_r + OCC_W'(1);
        XFER_OUT: occ_r <= occ_r - OCC_W'(1);
        default:  occ_r <= occ_r;
      endcase
    end
  end

  assign bus.Q         = data_s[DEPTH-1];
  assign bus.out_valid = valid_s[DEPTH-1];
  assign bus.occupancy = occ_r;

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: vector table, directed corner sequences and a
// randomized run against a queue-of-positions reference model.
module tb_dff_pipe;
  import dff_pipe_pkg::*;

  localparam logic [7:0] RV4 = 8'h00;
  localparam logic [7:0] RV1 = 8'hE7;

  logic clk;
  logic rst;

  dff_pipe_if #(.WIDTH(8), .OCC_W(clog2(5))) b4 ();
  dff_pipe_if #(.WIDTH(8), .OCC_W(clog2(2))) b1 ();

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV4)) dut4 (
    .clk(clk), .reset(rst), .bus(b4.slave)
  );
  dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(RV1)) dut1 (
    .clk(clk), .reset(rst), .bus(b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; int pos; } item_t;
  typedef struct {
    logic iv; logic [7:0] d; logic ordy; logic fl;
    logic e_ready; logic e_valid; logic [7:0] e_q; int e_occ;
  } vec_t;

  item_t      mq[$];
  int         m_np[$];
  logic [7:0] acc_list[$];
  int         m_depth;
  logic [7:0] m_rv;
  logic [7:0] m_q;
  int         n_vec, n_err, n_acc, n_out;
  bit         sel;
  logic       l_iv, l_ordy, l_fl;
  logic [7:0] l_d;
  logic       act_ready, act_valid;
  logic [7:0] act_q;
  int         act_occ;
  vec_t       tab[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    acc_list.delete();
    m_q = m_rv;
  endfunction

  // New slot of every held item after the coming edge; -1 marks the item leaving.
  function automatic void model_plan(input logic ordy);
    int lim;
    int p;
    m_np.delete();
    lim = m_depth;
    foreach (mq[k]) begin
      if (k == 0 && mq[k].pos == m_depth - 1 && ordy) begin
        m_np.push_back(-1);
      end else begin
        p = mq[k].pos + 1;
        if (p > lim - 1) p = lim - 1;
        if (p > m_depth - 1) p = m_depth - 1;
        m_np.push_back(p);
        lim = p;
      end
    end
  endfunction

  function automatic bit model_ready(input logic ordy, input logic fl);
    model_plan(ordy);
    if (!rst || fl) return 1'b0;
    foreach (m_np[k]) if (m_np[k] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    item_t nq[$];
    bit    acc;
    if (!rst || l_fl) begin
      model_reset();
      return;
    end
    acc = l_iv && model_ready(l_ordy, l_fl);
    foreach (mq[k]) begin
      if (m_np[k] >= 0) begin
        if (m_np[k] == m_depth - 1 && mq[k].pos != m_depth - 1) m_q = mq[k].data;
        nq.push_back('{data: mq[k].data, pos: m_np[k]});
      end
    end
    if (acc) begin
      nq.push_back('{data: l_d, pos: 0});
      acc_list.push_back(l_d);
      n_acc++;
      if (m_depth == 1) m_q = l_d;
    end
    mq = nq;
  endtask

  task automatic sample();
    if (sel) begin
      act_ready = b1.in_ready; act_valid = b1.out_valid;
      act_q = b1.Q; act_occ = int'(b1.occupancy);
    end else begin
      act_ready = b4.in_ready; act_valid = b4.out_valid;
      act_q = b4.Q; act_occ = int'(b4.occupancy);
    end
  endtask

  task automatic model_check();
    check("model_ready", act_ready, model_ready(l_ordy, l_fl));
    check("model_valid", act_valid, (mq.size() > 0) && (mq[0].pos == m_depth - 1));
    check("model_q", act_q, m_q);
    check("model_occ", act_occ, mq.size());
    if (act_valid && l_ordy && rst) begin
      n_out++;
      if (acc_list.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_order: got output %0h, expected no pending item", act_q);
      end else begin
        check("sb_order", act_q, acc_list.pop_front());
      end
    end
  endtask

  task automatic drive_and_sample(input logic iv, input logic [7:0] d,
                                  input logic ordy, input logic fl);
    l_iv = iv; l_d = d; l_ordy = ordy; l_fl = fl;
    if (sel) begin
      b1.in_valid = iv; b1.D = d; b1.out_ready = ordy; b1.flush = fl;
      b4.in_valid = 1'b0; b4.D = 8'h00; b4.out_ready = 1'b0; b4.flush = 1'b0;
    end else begin
      b4.in_valid = iv; b4.D = d; b4.out_ready = ordy; b4.flush = fl;
      b1.in_valid = 1'b0; b1.D = 8'h00; b1.out_ready = 1'b0; b1.flush = 1'b0;
    end
    @(negedge clk);
    sample();
    model_check();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    drive_and_sample(iv, d, ordy, fl);
    edge_step();
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_acc = 0; n_out = 0;
    sel = 1'b0; m_depth = 4; m_rv = RV4; rst = 1'b0;
    l_iv = 1'b0; l_d = 8'h00; l_ordy = 1'b0; l_fl = 1'b0;
    b4.in_valid = 1'b0; b4.D = 8'h00; b4.out_ready = 1'b0; b4.flush = 1'b0;
    b1.in_valid = 1'b0; b1.D = 8'h00; b1.out_ready = 1'b0; b1.flush = 1'b0;
    model_reset();

    // Latency of a single item, then back-pressure fill and drain.
    tab[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
    tab[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    tab[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    tab[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    tab[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1};
    tab[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 0};
    tab[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 0};
    tab[7]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 0};
    tab[8]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1};
    tab[9]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 2};
    tab[10] = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 3};
    tab[11] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 4};
    tab[12] = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 4};
    tab[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 4};
    tab[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 3};
    tab[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 2};
    tab[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 1};
    tab[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 0};

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    sample();
    check("rst_ready", act_ready, 1'b0);
    check("rst_valid", act_valid, 1'b0);
    check("rst_q", act_q, RV4);
    check("rst_occ", act_occ, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive_and_sample(tab[i].iv, tab[i].d, tab[i].ordy, tab[i].fl);
      check("tab_ready", act_ready, tab[i].e_ready);
      check("tab_valid", act_valid, tab[i].e_valid);
      check("tab_q", act_q, tab[i].e_q);
      check("tab_occ", act_occ, tab[i].e_occ);
      edge_step();
    end

    // Full pipe streaming: accept and emit every cycle.
    for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive_and_sample(1'b1, 8'(8'h14 + k), 1'b1, 1'b0);
      check("full_ready", act_ready, 1'b1);
      check("full_occ", act_occ, 4);
      check("full_valid", act_valid, 1'b1);
      check("full_q", act_q, 8'(8'h10 + k));
      edge_step();
    end
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with three items in flight; data presented during flush is dropped.
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0);
    step(1'b1, 8'hCC, 1'b0, 1'b0);
    drive_and_sample(1'b1, 8'hDD, 1'b0, 1'b1);
    check("flush_ready", act_ready, 1'b0);
    check("pre_flush_occ", act_occ, 3);
    edge_step();
    drive_and_sample(1'b0, 8'h00, 1'b1, 1'b0);
    check("flush_valid", act_valid, 1'b0);
    check("flush_occ", act_occ, 0);
    check("flush_q", act_q, RV4);
    edge_step();
    for (int k = 0; k < 5; k++) begin
      drive_and_sample(1'b0, 8'h00, 1'b1, 1'b0);
      check("flush_no_dd", act_valid, 1'b0);
      edge_step();
    end

    // Asynchronous reset between edges discards a full pipe immediately.
    for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h31 + k), 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    sample();
    check("async_valid", act_valid, 1'b0);
    check("async_q", act_q, RV4);
    check("async_occ", act_occ, 0);
    check("async_ready", act_ready, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    drive_and_sample(1'b1, 8'h3C, 1'b1, 1'b0);
    check("rel_ready", act_ready, 1'b1);
    edge_step();
    for (int k = 1; k <= 4; k++) begin
      drive_and_sample(1'b0, 8'h00, 1'b1, 1'b0);
      check("rel_valid", act_valid, k == 4);
      check("rel_q", act_q, (k == 4) ? 8'h3C : RV4);
      edge_step();
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with occasional flush.
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0);
    end
    repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Single-stage pipe with alternating consumer readiness.
    sel = 1'b1;
    m_depth = 1;
    m_rv = RV1;
    rst = 1'b0;
    model_reset();
    n_acc = 0;
    n_out = 0;
    drive_and_sample(1'b0, 8'h00, 1'b0, 1'b0);
    check("d1_rst_q", act_q, RV1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int k = 0; k < 80; k++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), (k % 2) == 0, 1'b0);
    end
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("d1_drained", acc_list.size(), 0);
    check("d1_out_count", n_out, n_acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, number of register stages; legal range 1..16.
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data register on reset or flush.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-006 D  input  WIDTH  write data, sampled when in_valid=1 and in_ready=1.
REQ-007 in_valid  input  1  D holds an item to accept.
REQ-008 in_ready  output  1  the pipe accepts D this cycle.
REQ-009 flush  input  1  synchronous clear of all stages.
REQ-010 Q  output  WIDTH  data of the last stage (DEPTH-1).
REQ-011 out_valid  output  1  Q holds a valid item.
REQ-012 out_ready  input  1  consumer takes Q this cycle.
REQ-013 occupancy  output  clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 Each stage i holds v[i] and data[i]; stage 0 is the input stage and stage DEPTH-1 drives Q and out_valid.
REQ-015 Stage DEPTH-1 moves when v[DEPTH-1]=1 and out_ready=1; stage i<DEPTH-1 moves when v[i]=1 and (v[i+1]=0 or stage i+1 moves).
REQ-016 Stage i is ready when v[i]=0 or stage i moves; in_ready equals ready of stage 0 AND NOT flush, combinationally.
REQ-017 Bubble collapse: an item advances whenever the next stage is empty, independent of out_ready.
REQ-018 Latency: with an empty pipe and out_ready=1, an item accepted at edge t drives out_valid=1 after edge t+DEPTH-1, i.e. DEPTH edges including capture.
REQ-019 Throughput: one item per cycle when out_ready=1, including when full; a full pipe with out_ready=1 accepts and emits in the same cycle.
REQ-020 data[i] loads only when stage i is written; otherwise it holds, so Q keeps its last value while out_valid=0.
REQ-021 Items leave in acceptance order; no item is dropped or duplicated except by flush or reset.
REQ-022 Flush=1 at an edge: all v[i] cleared, all data[i] set to RESET_VAL; no input accepted; an output transfer in that cycle (out_valid=1, out_ready=1) counts as consumed.
REQ-023 occupancy updates each edge: +1 on accept, -1 on output transfer, unchanged on both, 0 after flush.
REQ-024 DEPTH=1: single stage; in_ready = NOT v[0] OR out_ready, throughput one item per cycle.

Reset
REQ-025 reset=0 immediately, without a clock, forces all v[i]=0, all data[i]=RESET_VAL, out_valid=0, Q=RESET_VAL, occupancy=0.
REQ-026 While reset=0, in_ready=0 and no item is accepted; reset asserted mid-stream discards all in-flight items.
REQ-027 The first accept occurs at the first rising edge after reset returns to 1 with in_valid=1.

Structure
REQ-028 Package dff_pipe_pkg holds the default WIDTH/DEPTH constants and the clog2 helper used for the occupancy width.
REQ-029 Sub-module dff_pipe_stage implements one stage: valid bit plus WIDTH-bit data register, async active-low reset, load enable, synchronous clear; dff_pipe instantiates DEPTH of them.

Verification
REQ-030 WIDTH=8, DEPTH=4, out_ready=1, D=8'hA5 for one cycle -> out_valid=1 with Q=8'hA5 exactly 4 edges after acceptance, for one cycle only.
REQ-031 out_ready=0, send 5 items 1..5 -> items 1..4 accepted, occupancy=4, in_ready=0 on the 5th; set out_ready=1 -> Q emits 1,2,3,4,5 on consecutive cycles.
REQ-032 Full pipe, in_valid=1 and out_ready=1 continuously -> in_ready=1 every cycle, occupancy stays 4, one item out per cycle.
REQ-033 Pipe holding 3 items, flush=1 for one cycle -> out_valid=0, occupancy=0, Q=RESET_VAL next cycle; D presented during flush is not accepted.
REQ-034 reset=0 mid-stream between clock edges -> out_valid=0, Q=RESET_VAL immediately; after release, a new item 8'h3C appears after 4 edges.
REQ-035 DEPTH=1, alternating out_ready -> every accepted item emitted once, in order, with no loss.
